// File: rtl/sinc3_decim.sv
// sinc3_decim: third-order CIC (sinc3) decimator for a 1-bit sigma-delta bitstream.
// Three clock-rate integrators feed three decimated-rate combs. A new result is
// produced every R = osr+1 clocks and is marked by a one-clock valid pulse.
// Optional macro SINC3_SIGNED_EN: maps sdi=1/0 to +1/-1 instead of 1/0, giving
// two's-complement results in -R^3..+R^3.
module sinc3_decim #(
    parameter int OSR_WIDTH = 16,
    localparam int RES_WIDTH = 3 * OSR_WIDTH
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic                 sdi,
    input  logic [OSR_WIDTH-1:0] osr,
    output logic [RES_WIDTH-1:0] data,
    output logic                 valid
);

    logic [RES_WIDTH-1:0] x;
    logic [RES_WIDTH-1:0] int1;
    logic [RES_WIDTH-1:0] int2;
    logic [RES_WIDTH-1:0] int3;
    logic [RES_WIDTH-1:0] int3_next;
    logic [RES_WIDTH-1:0] z1;
    logic [RES_WIDTH-1:0] z2;
    logic [RES_WIDTH-1:0] z3;
    logic [RES_WIDTH-1:0] d1;
    logic [RES_WIDTH-1:0] d2;
    logic [RES_WIDTH-1:0] d3;
    logic [OSR_WIDTH-1:0] cnt;
    logic [OSR_WIDTH-1:0] osr_q;
    logic [OSR_WIDTH-1:0] osr_active;
    logic                 first;
    logic                 frame_end;

    // Map the modulator bit onto the integrator input sample.
    always_comb begin
        x = '0;
`ifdef SINC3_SIGNED_EN
        x = sdi ? RES_WIDTH'(1) : '1;
`else
        x = {{(RES_WIDTH-1){1'b0}}, sdi};
`endif
    end

    // Until the first active edge the live osr input is used directly, so the
    // ratio tracks osr throughout reset; afterwards the latched copy is used.
    assign osr_active = first ? osr : osr_q;
    assign frame_end  = (cnt == osr_active);

    // The comb samples the value I3 takes on this edge (I3 + I2), so sample k
    // corresponds to time k*R and the all-zero reset history is genuine.
    assign int3_next = int3 + int2;
    assign d1        = int3_next - z1;
    assign d2        = d1 - z2;
    assign d3        = d2 - z3;

    // Three cascaded integrators running at clock rate, modulo 2^RES_WIDTH.
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
        end else begin
            int1 <= int1 + x;
            int2 <= int2 + int1;
            int3 <= int3_next;
        end
    end

    // Decimation counter; the ratio is re-latched at the first edge and at each wrap.
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            cnt   <= '0;
            osr_q <= '0;
            first <= 1'b1;
        end else begin
            first <= 1'b0;
            if (frame_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (first || frame_end) begin
                osr_q <= osr;
            end
        end
    end

    // Decimated-rate comb delays, output register and the one-clock valid pulse.
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            z1    <= '0;
            z2    <= '0;
            z3    <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= frame_end;
            if (frame_end) begin
                z1   <= int3_next;
                z2   <= d1;
                z3   <= d2;
                data <= d3;
            end
        end
    end

endmodule

// File: tb/tb_sinc3_decim.sv
// tb_sinc3_decim: directed, table-driven bench for sinc3_decim.
// Valid is observed on the falling edge after the R-th active rising edge that
// follows reset release, and every R falling edges after that.
module tb_sinc3_decim;

    logic        clock;
    logic        aclr;
    logic        sdi;
    logic [15:0] osr;
    logic [47:0] data;
    logic        valid;
    logic [1:0]  osr_small;
    logic [5:0]  data_small;
    logic        valid_small;

    int n_applied;
    int n_miscompares;

    int          got_n;
    int          got_at [16];
    logic [47:0] got_data [16];
    int          small_n;
    int          small_at [16];
    logic [5:0]  small_data [16];

    typedef struct {
        logic [15:0] osr;
        int          mode;
        int          nv;
        int          exact_from;
        logic [47:0] expect_data;
    } vec_t;

    vec_t vecs [7];

    sinc3_decim dut (
        .clock (clock),
        .aclr  (aclr),
        .sdi   (sdi),
        .osr   (osr),
        .data  (data),
        .valid (valid)
    );

    // A 2-bit ratio makes the R^3 = 2^RES_WIDTH wrap-around case cheap to reach.
    sinc3_decim #(.OSR_WIDTH(2)) dut_small (
        .clock (clock),
        .aclr  (aclr),
        .sdi   (sdi),
        .osr   (osr_small),
        .data  (data_small),
        .valid (valid_small)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // mode 0: constant 0, mode 1: constant 1, mode 2: alternating starting with 1
    function automatic logic pat(input int mode, input int n);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return (n % 2) == 1;
    endfunction

    task automatic checkOutput(input string name, input logic [47:0] got, input logic [47:0] want);
        n_applied++;
        if (got !== want) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic doReset(input logic [15:0] osr_val);
        @(negedge clock);
        aclr = 1'b0;
        osr  = osr_val;
        repeat (2) @(negedge clock);
    endtask

    // Release reset on a falling edge and run for a fixed number of cycles,
    // recording the cycle index and value of every valid from both instances.
    task automatic applyStimulus(input int budget, input int mode, input int chg_at,
                                 input logic [15:0] chg_osr);
        got_n   = 0;
        small_n = 0;
        sdi     = pat(mode, 1);
        aclr    = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clock);
            if (valid && got_n < 16) begin
                got_at[got_n]   = n;
                got_data[got_n] = data;
                got_n++;
            end
            if (valid_small && small_n < 16) begin
                small_at[small_n]   = n;
                small_data[small_n] = data_small;
                small_n++;
            end
            if (n == chg_at) osr = chg_osr;
            sdi = pat(mode, n + 1);
        end
    endtask

    initial begin
        int r;
        int first_valid;
        logic [47:0] first_data;

        n_applied     = 0;
        n_miscompares = 0;
        aclr          = 1'b0;
        sdi           = 1'b0;
        osr           = 16'd399;
        osr_small     = 2'd3;

        vecs[0] = '{osr: 16'd399, mode: 1, nv: 6, exact_from: 2, expect_data: 48'd64000000};
`ifdef SINC3_SIGNED_EN
        vecs[1] = '{osr: 16'd399, mode: 0, nv: 5, exact_from: 2, expect_data: 48'(-64000000)};
        vecs[3] = '{osr: 16'd399, mode: 2, nv: 5, exact_from: 3, expect_data: 48'd0};
`else
        vecs[1] = '{osr: 16'd399, mode: 0, nv: 5, exact_from: 2, expect_data: 48'd0};
        vecs[3] = '{osr: 16'd399, mode: 2, nv: 5, exact_from: 3, expect_data: 48'd32000000};
`endif
        vecs[2] = '{osr: 16'd99,  mode: 1, nv: 6, exact_from: 2, expect_data: 48'd1000000};
        vecs[4] = '{osr: 16'd0,   mode: 1, nv: 5, exact_from: 2, expect_data: 48'd1};
        vecs[5] = '{osr: 16'd1,   mode: 1, nv: 5, exact_from: 2, expect_data: 48'd8};
        vecs[6] = '{osr: 16'd2,   mode: 1, nv: 5, exact_from: 2, expect_data: 48'd27};

        // Outputs held at zero while reset is asserted.
        repeat (3) @(negedge clock);
        checkOutput("reset_data", data, 48'd0);
        checkOutput("reset_valid", {47'd0, valid}, 48'd0);
        checkOutput("reset_data_small", {42'd0, data_small}, 48'd0);

        // Table-driven steady-state vectors.
        for (int v = 0; v < 7; v++) begin
            r = int'(vecs[v].osr) + 1;
            doReset(vecs[v].osr);
            applyStimulus(r * vecs[v].nv, vecs[v].mode, -1, 16'd0);
            checkOutput($sformatf("v%0d_valid_count", v), 48'(got_n), 48'(vecs[v].nv));
            if (got_n > 0)
                checkOutput($sformatf("v%0d_first_valid_at", v), 48'(got_at[0]), 48'(r));
            for (int i = 1; i < got_n; i++)
                checkOutput($sformatf("v%0d_spacing_%0d", v, i), 48'(got_at[i] - got_at[i-1]), 48'(r));
            for (int i = vecs[v].exact_from; i < got_n; i++)
                checkOutput($sformatf("v%0d_data_%0d", v, i), got_data[i], vecs[v].expect_data);
        end

        // Ratio change mid-frame: the running 400-clock frame finishes, then 100-clock frames.
        doReset(16'd399);
        applyStimulus(700, 1, 200, 16'd99);
        checkOutput("osr_change_count", 48'(got_n), 48'd4);
        checkOutput("osr_change_v0", 48'(got_at[0]), 48'd400);
        checkOutput("osr_change_v1", 48'(got_at[1]), 48'd500);
        checkOutput("osr_change_v2", 48'(got_at[2]), 48'd600);
        checkOutput("osr_change_v3", 48'(got_at[3]), 48'd700);

        // Reset asserted mid-frame aborts the frame and clears outputs at once.
        doReset(16'd99);
        sdi         = 1'b1;
        aclr        = 1'b1;
        first_valid = 0;
        first_data  = '0;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clock);
            if (valid && first_valid == 0) begin
                first_valid = n;
                first_data  = data;
            end
        end
        checkOutput("midreset_pre_valid_at", 48'(first_valid), 48'd100);
        checkOutput("midreset_pre_transient", first_data, 48'd161700);
        aclr = 1'b0;
        #1;
        checkOutput("midreset_data_cleared", data, 48'd0);
        checkOutput("midreset_valid_cleared", {47'd0, valid}, 48'd0);
        repeat (2) @(negedge clock);
        applyStimulus(100, 1, -1, 16'd0);
        checkOutput("midreset_post_count", 48'(got_n), 48'd1);
        if (got_n > 0)
            checkOutput("midreset_post_valid_at", 48'(got_at[0]), 48'd100);

        // Small instance, R=4, all ones: transient 4, 44, then R^3 = 64 wraps to 0.
        doReset(16'd399);
        applyStimulus(16, 1, -1, 16'd0);
        checkOutput("small_count", 48'(small_n), 48'd4);
        checkOutput("small_v0_at", 48'(small_at[0]), 48'd4);
        checkOutput("small_v0", {42'd0, small_data[0]}, 48'd4);
        checkOutput("small_v1", {42'd0, small_data[1]}, 48'd44);
        checkOutput("small_v2", {42'd0, small_data[2]}, 48'd0);
        checkOutput("small_v3", {42'd0, small_data[3]}, 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
